// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: framebuffer geometry, port widths and slot encoding shared by fb_arbiter.
package fb_arb_pkg;
    localparam int HPOS_WIDTH  = 10;
    localparam int VPOS_WIDTH  = 10;
    localparam int SCALE_SHIFT = 2;
    localparam int FB_W        = 160;
    localparam int FB_H        = 120;
    localparam int FB_X_WIDTH  = 8;
    localparam int FB_Y_WIDTH  = 7;
    localparam int DATA_WIDTH  = 3;
    localparam int ADDR_WIDTH  = 15;
    typedef enum logic {SLOT_DISP, SLOT_WR} slot_t;
endpackage

// File: rtl/fb_arbiter_addr_calc.sv
// fb_addr_calc: linear framebuffer address y*W + x, unsigned at full address width.
module fb_addr_calc #(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int AW = 15,
    parameter int W  = 160
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic [AW-1:0] addr
);
    assign addr = AW'(y) * AW'(W) + AW'(x);
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: time-slices one pixel RAM between display fetch (pix_en clk) and a writer (other clk).
// Define FB_ARB_BLANK_BURST_EN to also hand display slots to the writer while display_on=0.
module fb_arbiter
    import fb_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_en,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic                  display_on,
    input  logic [HPOS_WIDTH-1:0] hpos,
    input  logic [VPOS_WIDTH-1:0] vpos,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [FB_X_WIDTH-1:0] wr_x,
    input  logic [FB_Y_WIDTH-1:0] wr_y,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  pix_hsync,
    output logic                  pix_vsync,
    output logic                  pix_display_on,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  wr_oob
);
    slot_t                 slot;
    logic                  wr_slot, in_range, rd_pending;
    logic [HPOS_WIDTH-1:0] disp_x;
    logic [VPOS_WIDTH-1:0] disp_y;
    logic [ADDR_WIDTH-1:0] disp_addr, wr_addr;

    assign slot   = pix_en ? SLOT_DISP : SLOT_WR;
    assign disp_x = hpos >> SCALE_SHIFT;
    assign disp_y = vpos >> SCALE_SHIFT;

    fb_addr_calc #(.XW(HPOS_WIDTH), .YW(VPOS_WIDTH), .AW(ADDR_WIDTH), .W(FB_W)) u_disp_addr (
        .x(disp_x), .y(disp_y), .addr(disp_addr)
    );
    fb_addr_calc #(.XW(FB_X_WIDTH), .YW(FB_Y_WIDTH), .AW(ADDR_WIDTH), .W(FB_W)) u_wr_addr (
        .x(wr_x), .y(wr_y), .addr(wr_addr)
    );

`ifdef FB_ARB_BLANK_BURST_EN
    assign wr_slot = slot == SLOT_WR || !display_on;
`else
    assign wr_slot = slot == SLOT_WR;
`endif

    assign in_range  = 32'(wr_x) < FB_W && 32'(wr_y) < FB_H;
    assign wr_ready  = !reset && wr_slot && wr_valid;
    assign mem_we    = wr_ready && in_range;
    assign mem_addr  = wr_slot ? wr_addr : disp_addr;
    assign mem_wdata = wr_data;

    // Syncs are sampled in the second clk of the pixel, alongside the returning read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending     <= 1'b0;
            pix_hsync      <= 1'b1;
            pix_vsync      <= 1'b1;
            pix_display_on <= 1'b0;
            pix_data       <= '0;
            wr_oob         <= 1'b0;
        end else begin
            if (pix_en) begin
                rd_pending <= display_on;
            end else begin
                pix_data       <= rd_pending ? mem_rdata : '0;
                pix_hsync      <= hsync;
                pix_vsync      <= vsync;
                pix_display_on <= display_on;
            end
            if (wr_ready && !in_range) wr_oob <= 1'b1;
        end
    end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Shares one single-port pixel memory between the VGA display fetch and a drawing client. The block sits between the VGA timing generator (hpos/vpos/sync at 25 MHz pixel rate on the 50 MHz clock) and the framebuffer RAM. Each pixel period has two clock slots: the display read owns the first and the writer owns the second. Read data returns with sync/display_on re-timed by one pixel so they stay aligned.

## Interface
- HPOS_WIDTH, 10, timing generator hpos width
- VPOS_WIDTH, 10, timing generator vpos width
- SCALE_SHIFT, 2, screen-to-framebuffer downscale as log2 (640x480 → 160x120)
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- FB_X_WIDTH, 8 / FB_Y_WIDTH, 7, writer coordinate widths
- DATA_WIDTH, 3, pixel width (RGB)
- ADDR_WIDTH, 15, memory address width
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- pix_en  in  1  high in the first clk of each pixel, when hpos/vpos/hsync/vsync/display_on first hold the new pixel
- hsync, vsync, display_on  in  1 each  from the timing generator
- hpos  in  HPOS_WIDTH / vpos  in  VPOS_WIDTH  current screen position
- wr_valid  in  1 / wr_ready  out  1  writer handshake
- wr_x  in  FB_X_WIDTH / wr_y  in  FB_Y_WIDTH / wr_data  in  DATA_WIDTH  writer request
- mem_addr  out  ADDR_WIDTH / mem_we  out  1 / mem_wdata  out  DATA_WIDTH  memory port
- mem_rdata  in  DATA_WIDTH  read data, one clk after the address
- pix_hsync, pix_vsync, pix_display_on  out  1 each  syncs delayed one pixel
- pix_data  out  DATA_WIDTH  pixel colour aligned with pix_*
- wr_oob  out  1  sticky flag: a write was out of range

## Operation
- Slot selection: pix_en=1 is the display slot; pix_en=0 is the writer slot.
- Display slot:
  - mem_addr = (vpos>>SCALE_SHIFT)*FB_W + (hpos>>SCALE_SHIFT), mem_we=0.
  - rd_pending ← display_on.
- Writer slot:
  - wr_ready = wr_valid.
  - mem_addr = wr_y*FB_W + wr_x.
  - mem_we = 1 when in range; mem_wdata = wr_data.
- Writer handshake:
  - A transfer occurs when wr_valid && wr_ready.
  - The writer must hold wr_valid and its data stable until ready.
  - wr_ready is never high in a display slot, except in the blank-burst case below.
- Out of range (wr_x ≥ FB_W or wr_y ≥ FB_H):
  - The handshake still completes (wr_ready=1).
  - mem_we=0 and wr_oob ← 1.
  - wr_oob stays set until reset.
- Arithmetic: both addresses are unsigned and computed at full ADDR_WIDTH; products never exceed FB_W*FB_H−1 for in-range inputs.
- Reset values:
  - pix_hsync=1, pix_vsync=1, pix_display_on=0, pix_data=0, wr_oob=0, rd_pending=0.
  - While reset is asserted: mem_we=0, wr_ready=0.

## Timing
- mem_addr, mem_we, mem_wdata and wr_ready are combinational from the slot and inputs.
- The read is issued in cycle t (pix_en=1); mem_rdata is valid in cycle t+1.
- At the clk edge ending t+1:
  - pix_data ← rd_pending ? mem_rdata : 0.
  - pix_hsync/pix_vsync/pix_display_on ← hsync/vsync/display_on (still held for the same pixel).
- Outputs change at t+2. Latency is 2 clk (one pixel), and pix_* stay constant for 2 clk.
- Write bandwidth: in the baseline build, at most one write per pixel (every other clk).
- Simultaneous events: a wr_valid arriving in a display slot waits until the next writer slot. The display read is never delayed or dropped.
- Reset mid-operation: an in-flight write is suppressed immediately (mem_we forced 0), and any pending read is discarded.

## Configuration
- FB_ARB_BLANK_BURST_EN defined:
  - In a display slot with display_on=0, the slot goes to the writer: wr_ready = wr_valid and the write is performed.
  - This allows one write per clk during blanking.
  - rd_pending ← 0, so pix_data=0.
- FB_ARB_BLANK_BURST_EN undefined: display slots never grant the writer, even during blanking.

## Structure
- Package fb_arb_pkg holds:
  - FB_W, FB_H, SCALE_SHIFT, the width constants
  - the slot enum SLOT_DISP / SLOT_WR
- Sub-module fb_addr_calc (y*FB_W + x → ADDR_WIDTH), instanced twice: once for the display address and once for the writer address.

## Test plan
- Reset asserted mid-frame → pix_hsync=1, pix_vsync=1, pix_display_on=0, pix_data=0, wr_oob=0, mem_we=0, wr_ready=0.
- Active area, hpos=8, vpos=4, pix_en=1 → mem_addr=162, mem_we=0; mem_rdata=5 next clk → pix_data=5 with pix_display_on=1 two clk after the address.
- wr_valid with x=3, y=2, data=6 raised in a display slot during active video → wr_ready=0 that clk; next clk wr_ready=1, mem_addr=323, mem_we=1, mem_wdata=6.
- Write with x=160, y=0 → wr_ready=1, mem_we=0, wr_oob=1; wr_oob stays 1 for the following 1000 clk until reset.
- Blanking (display_on=0), 4 back-to-back valid writes → 4 transfers in 4 clk with the macro, 8 clk without; pix_data=0 throughout.
- Reset asserted during a writer slot with wr_valid=1 → mem_we=0 and wr_ready=0 in that same clk; after release the first transfer waits for the next pix_en=0 slot.
